weight_mem_responder: RTL and testbench
=======================================

# weight_mem_responder

Weight-memory responder serving the address/read-strobe requests issued by the load/store array's weight address generator. It holds the weight page store in a single-port synchronous RAM and is loaded by the host through a write port. It returns read data on a fixed-latency pipeline together with a valid flag. A small mode FSM keeps host loading and MXU read traffic mutually exclusive.

## Interface
Parameters:
- data_in_mem, 64, weight word width
- address_leng_wm, 32, request address width (matches the load/store array `wm_address`)
- DEPTH_LOG2, 10, log2 of RAM depth in words; addresses at or above 2^DEPTH_LOG2 are out of range
- READ_LATENCY, 2, cycles from accepted request to `rd_valid`; legal range 1..4

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start_load  in  1  pulse: IDLE→LOAD
- load_done  in  1  pulse: LOAD→SERVE
- release  in  1  pulse: SERVE→IDLE
- wr_en  in  1  host write strobe
- wr_addr  in  address_leng_wm  host write address
- wr_data  in  data_in_mem  host write data
- wr_ready  out  1  write accepted this cycle when high with `wr_en`
- rd_req  in  1  read strobe (`read_weight_memory`)
- rd_addr  in  address_leng_wm  read address (`wm_address`)
- rd_data  out  data_in_mem  read data (`data_from_weight_memory`)
- rd_valid  out  1  `rd_data` valid this cycle
- rd_err  out  1  error flag, aligned with `rd_valid` timing
- state  out  2  0=IDLE, 1=LOAD, 2=SERVE
- words_loaded  out  DEPTH_LOG2+1  count of accepted in-range writes since the last `start_load`

## Operation
- FSM transitions:
  - IDLE: `start_load` → LOAD; clears `words_loaded`.
  - LOAD: `load_done` → SERVE.
  - SERVE: `release` → IDLE.
  - All other pulses are ignored in a given state.
- Simultaneous pulses: only the pulse legal for the current state acts.
- `wr_ready` = 1 only in LOAD. It is combinational from state.
- Accepted write (`wr_en & wr_ready`):
  - Addr in range: RAM[wr_addr[DEPTH_LOG2-1:0]] ← `wr_data` at the edge; `words_loaded` +1, saturating at 2^DEPTH_LOG2.
  - Addr out of range: the write is dropped and the count is unchanged.
- Read request is accepted in every cycle with `rd_req`=1, one per cycle, fully pipelined:
  - SERVE and addr in range: returns RAM data with `rd_err`=0.
  - Otherwise (wrong state or out of range): returns `rd_data`=0 with `rd_valid`=1 and `rd_err`=1.
- Every accepted request produces exactly one `rd_valid` pulse, in order.
- Upper address bits: only the bits above DEPTH_LOG2-1 participate in the range check. There is no wrap-around.
- The RAM is single-port. Reads and writes never coexist because of the FSM, so no arbitration is needed.
- Read-after-write: a write at edge N is visible to a read accepted at edge N+1 or later.
- Reset: the FSM goes to IDLE, the pipeline valid bits are cleared, `words_loaded`=0. RAM contents are NOT cleared.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_err`=0, `rd_data`=0
  - `state`=IDLE, `wr_ready`=0, `words_loaded`=0
- Read latency: request sampled at edge N → `rd_valid`/`rd_data`/`rd_err` registered outputs valid after edge N+READ_LATENCY. There are no bubbles.
- Between valid pulses, `rd_data` is held at its last value; `rd_err` is 0.
- A state change at edge N affects requests sampled at edge N+1 onward. In-flight reads complete with the error status decided at their acceptance.
- `release` with reads in flight: the in-flight reads still return their data.
- Reset asserted mid-pipeline: all in-flight responses are discarded, and no `rd_valid` appears after deassertion until a new request is made.
- `words_loaded` updates at the same edge as the write.

## Test plan
- Load, then burst read:
  - Stimulus: `start_load`; write addr 0..3 = 0x11,0x22,0x33,0x44; `load_done`; `rd_req` on four consecutive cycles, addr 0..3.
  - Required: `rd_valid` high for 4 consecutive cycles starting READ_LATENCY after the first request; data 0x11..0x44; `words_loaded`=4.
- Wrong-state read:
  - Stimulus: in LOAD, `rd_req` addr 0.
  - Required: READ_LATENCY later `rd_valid`=1, `rd_err`=1, `rd_data`=0.
- Out-of-range:
  - Stimulus: in LOAD, write addr 2^DEPTH_LOG2. Then in SERVE, read the same addr.
  - Required: `words_loaded` unchanged; read returns `rd_err`=1, data 0.
- Write gating:
  - Stimulus: in SERVE, `wr_en` to addr 1 with 0xFF.
  - Required: `wr_ready`=0; a later read of addr 1 returns the prior value.
- Release with in-flight reads:
  - Stimulus: `rd_req` at edge N, `release` at edge N.
  - Required: the response arrives READ_LATENCY later with `rd_err`=0. A request at N+1 returns `rd_err`=1.
- Reset mid-pipeline:
  - Stimulus: assert reset one cycle after `rd_req`; deassert.
  - Required: no `rd_valid`; `state`=IDLE. After reloading the FSM to SERVE, a read of addr 0 still returns 0x11.

Source files
------------

// File: rtl/weight_mem_responder.sv
// Weight-memory responder: host-loaded single-port weight RAM serving MXU reads
// through a fixed-latency pipeline, with a mode FSM separating load and serve phases.
module weight_mem_responder #(
   parameter int data_in_mem     = 64,
   parameter int address_leng_wm = 32,
   parameter int DEPTH_LOG2      = 10,
   parameter int READ_LATENCY    = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       start_load_i,
   input  logic                       load_done_i,
   input  logic                       release_i,
   input  logic                       wr_en_i,
   input  logic [address_leng_wm-1:0] wr_addr_i,
   input  logic [data_in_mem-1:0]     wr_data_i,
   output logic                       wr_ready_o,
   input  logic                       rd_req_i,
   input  logic [address_leng_wm-1:0] rd_addr_i,
   output logic [data_in_mem-1:0]     rd_data_o,
   output logic                       rd_valid_o,
   output logic                       rd_err_o,
   output logic [1:0]                 state_o,
   output logic [DEPTH_LOG2:0]        words_loaded_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SERVE = 2'd2
   } state_t;

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int PD    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
   localparam logic [DEPTH_LOG2:0] WORDS_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] WORDS_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

   state_t                    state_q, state_d;
   logic [DEPTH_LOG2:0]       words_q, words_d;
   logic [data_in_mem-1:0]    mem [DEPTH];
   logic [data_in_mem-1:0]    rdata_q;
   logic [data_in_mem-1:0]    pd_q [PD];
   logic [READ_LATENCY-1:0]   pv_q, pe_q;
   logic [data_in_mem-1:0]    rd_data_q;
   logic                      rd_valid_q, rd_err_q;

   logic wr_in_range_s, rd_in_range_s, wr_fire_s, rd_ram_en_s, rd_err_s;
   logic [data_in_mem-1:0] last_data_s;

   assign wr_in_range_s = ~|wr_addr_i[address_leng_wm-1:DEPTH_LOG2];
   assign rd_in_range_s = ~|rd_addr_i[address_leng_wm-1:DEPTH_LOG2];
   assign wr_fire_s     = wr_en_i & wr_ready_o & wr_in_range_s;
   assign rd_err_s      = ~((state_q == ST_SERVE) & rd_in_range_s);
   // RAM is only read when the data is actually returned, so it never sees a write and read together
   assign rd_ram_en_s   = rd_req_i & ~rd_err_s;
   assign last_data_s   = (READ_LATENCY == 1) ? rdata_q : pd_q[PD-1];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         words_q <= words_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_load_i) state_d = ST_LOAD;  else state_d = ST_IDLE;
         ST_LOAD:  if (load_done_i)  state_d = ST_SERVE; else state_d = ST_LOAD;
         ST_SERVE: if (release_i)    state_d = ST_IDLE;  else state_d = ST_SERVE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ready_o = (state_q == ST_LOAD);
      state_o    = state_q;
   end

   always_comb begin
      words_d = words_q;
      if ((state_q == ST_IDLE) && start_load_i) begin
         words_d = '0;
      end else if (wr_fire_s && (words_q != WORDS_FULL)) begin
         words_d = words_q + WORDS_ONE;
      end else begin
         words_d = words_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire_s) begin
         mem[wr_addr_i[DEPTH_LOG2-1:0]] <= wr_data_i;
      end else if (rd_ram_en_s) begin
         rdata_q <= mem[rd_addr_i[DEPTH_LOG2-1:0]];
      end
   end

   // Valid/error tags ride alongside the data so status is fixed at acceptance
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pv_q <= '0;
         pe_q <= '0;
      end else begin
         pv_q[0] <= rd_req_i;
         pe_q[0] <= rd_err_s;
         for (int k = 1; k < READ_LATENCY; k++) begin
            pv_q[k] <= pv_q[k-1];
            pe_q[k] <= pe_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      pd_q[0] <= rdata_q;
      for (int k = 1; k < PD; k++) begin
         pd_q[k] <= pd_q[k-1];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= pv_q[READ_LATENCY-1];
         rd_err_q   <= pv_q[READ_LATENCY-1] & pe_q[READ_LATENCY-1];
         if (pv_q[READ_LATENCY-1]) begin
            rd_data_q <= pe_q[READ_LATENCY-1] ? '0 : last_data_s;
         end
      end
   end

   assign rd_valid_o     = rd_valid_q;
   assign rd_err_o       = rd_err_q;
   assign rd_data_o      = rd_data_q;
   assign words_loaded_o = words_q;

endmodule

// File: tb/tb_weight_mem_responder.sv
// Scoreboard bench for weight_mem_responder: the driver queues expected read
// responses, a negedge monitor pops and compares them with data and latency.
module tb_weight_mem_responder;
   localparam int W  = 64;
   localparam int AW = 32;
   localparam int D  = 10;
   localparam int L  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_load = 1'b0, load_done = 1'b0, rel = 1'b0;
   logic          wr_en = 1'b0, rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_ready, rd_valid, rd_err;
   logic [W-1:0]  rd_data;
   logic [1:0]    state;
   logic [D:0]    words_loaded;

   typedef struct {
      logic         err;
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] last_data = '0;

   weight_mem_responder #(
      .data_in_mem(W), .address_leng_wm(AW), .DEPTH_LOG2(D), .READ_LATENCY(L)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .start_load_i(start_load), .load_done_i(load_done), .release_i(rel),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .rd_valid_o(rd_valid), .rd_err_o(rd_err),
      .state_o(state), .words_loaded_o(words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One negedge-driven cycle of stimulus; a read request queues its expected response
   task automatic step(input logic sl, input logic ld, input logic rl,
                       input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic rq, input logic [AW-1:0] ra,
                       input logic ee, input logic [W-1:0] ed);
      exp_t e;
      @(negedge clk);
      start_load = sl; load_done = ld; rel = rl;
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_req = rq; rd_addr = ra;
      if (rq) begin
         e.err = ee; e.data = ed; e.cyc = cyc + 1 + L;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic ee, input logic [W-1:0] ed);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a, ee, ed);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      step(1'b0, 1'b0, 1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, '0);
   endtask

   // Monitor: compares every response against the scoreboard, and the idle-cycle hold behaviour
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         last_data = '0;
      end else if (rd_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rd_err", {63'd0, rd_err}, {63'd0, e.err});
            chk("rd_data", rd_data, e.data);
            chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            last_data = e.data;
         end
      end else begin
         chk("idle_err", {63'd0, rd_err}, 64'd0);
         chk("idle_hold", rd_data, last_data);
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst_err", {63'd0, rd_err}, 64'd0);
      chk("rst_data", rd_data, 64'd0);
      chk("rst_state", {62'd0, state}, 64'd0);
      chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
      chk("rst_words", 64'(words_loaded), 64'd0);

      // IDLE read is a wrong-state error
      rd(32'd0, 1'b1, 64'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      idle();
      chk("load_state", {62'd0, state}, 64'd1);
      chk("load_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("load_words0", 64'(words_loaded), 64'd0);

      wr(32'd0, 64'h11); wr(32'd1, 64'h22); wr(32'd2, 64'h33); wr(32'd3, 64'h44);
      wr(32'd1024, 64'hDEAD);
      idle();
      chk("words_after_load", 64'(words_loaded), 64'd4);

      rd(32'd0, 1'b1, 64'd0);
      // start_load and release are both illegal in LOAD
      step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      idle();
      chk("illegal_pulses_ignored", {62'd0, state}, 64'd1);

      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      idle();
      chk("serve_state", {62'd0, state}, 64'd2);
      wr(32'd1, 64'hFF);
      chk("serve_wr_ready", {63'd0, wr_ready}, 64'd0);
      idle();
      chk("serve_words", 64'(words_loaded), 64'd4);

      rd(32'd0, 1'b0, 64'h11); rd(32'd1, 1'b0, 64'h22);
      rd(32'd2, 1'b0, 64'h33); rd(32'd3, 1'b0, 64'h44);
      rd(32'd1024, 1'b1, 64'd0);
      rd(32'h8000_0001, 1'b1, 64'd0);
      rd(32'd1, 1'b0, 64'h22);
      idle();

      // Release alongside a read: that read completes clean, the next one errors
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 32'd2, 1'b0, 64'h33);
      rd(32'd3, 1'b1, 64'd0);
      idle();
      chk("release_state", {62'd0, state}, 64'd0);
      repeat (4) idle();

      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      idle();
      chk("reload_words_clear", 64'(words_loaded), 64'd0);
      chk("reload_state", {62'd0, state}, 64'd2);

      rd(32'd0, 1'b0, 64'h11);
      idle();
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) idle();
      chk("post_reset_state", {62'd0, state}, 64'd0);

      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      rd(32'd0, 1'b0, 64'h11);
      idle();

      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
